// File: rtl/sweep_seq_pkg.sv
// Shared types and helpers for the sweep sequencer.
// The SWEEP_HEADER_EN macro adds the three framing-byte states to the state enum.
package sweep_seq_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_DAC_WR,
      ST_DAC_WAIT,
      ST_SETTLE,
      ST_ADC_CONV,
      ST_ADC_WAIT,
      ST_STORE,
`ifdef SWEEP_HEADER_EN
      ST_HDR_SYNC0,
      ST_HDR_SYNC1,
      ST_HDR_COUNT,
`endif
      ST_TX_MSB,
      ST_TX_LSB,
      ST_DONE
   } sweep_state_e;

   // Each transmitted byte goes through load, one-cycle pulse, then wait for done.
   typedef enum logic [1:0] {
      TXP_LOAD,
      TXP_PULSE,
      TXP_WAIT
   } tx_phase_e;

   localparam logic [7:0] HDR_SYNC0 = 8'hA5;
   localparam logic [7:0] HDR_SYNC1 = 8'h5A;

   // Bits needed to index n items (at least one bit).
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Bits needed to hold the values 0..n.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/sweep_result_buf.sv
// Result buffer for the sweep sequencer: one write port, one registered read port.
// Contents are never reset.
module sweep_result_buf
   import sweep_seq_pkg::*;
#(
   parameter int Width = 12,
   parameter int Depth = 64,
   parameter int AddrW = idx_width(Depth)
) (
   input  logic             clk_i,
   input  logic             wr_en_i,
   input  logic [AddrW-1:0] wr_addr_i,
   input  logic [Width-1:0] wr_data_i,
   input  logic [AddrW-1:0] rd_addr_i,
   output logic [Width-1:0] rd_data_o
);

   logic [Width-1:0] mem [Depth];
   logic [Width-1:0] rd_data_q;
   logic [Width-1:0] rd_data_d;

   // Synchronous write of one result word.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem[wr_addr_i] <= wr_data_i;
      end
   end

   // Array lookup for the read port; registered below.
   always_comb begin
      rd_data_d = mem[rd_addr_i];
   end

   // Read data register so the word is stable a cycle after the address.
   always_ff @(posedge clk_i) begin
      rd_data_q <= rd_data_d;
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sweep_seq_ctrl.sv
// Sweep sequencer: steps the DAC through NumPoints codes, averages NumCh ADC
// channels per point into the result buffer, then streams the buffer to the
// UART as MSB/LSB byte pairs. Defining SWEEP_HEADER_EN prefixes the stream
// with 0xA5, 0x5A and the word count.
module sweep_seq_ctrl
   import sweep_seq_pkg::*;
#(
   parameter int NumPoints    = 32,
   parameter int NumCh        = 2,
   parameter int AvgLog2      = 2,
   parameter int DataWidth    = 12,
   parameter int SettleCycles = 100
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          start_i,
   input  logic                          abort_i,
   output logic                          dac_start_o,
   output logic [idx_width(NumPoints)-1:0] dac_idx_o,
   input  logic                          dac_done_i,
   output logic                          adc_start_o,
   output logic [idx_width(NumCh)-1:0]   adc_ch_o,
   input  logic                          adc_done_i,
   input  logic [DataWidth-1:0]          adc_data_i,
   output logic                          tx_start_o,
   output logic [7:0]                    tx_data_o,
   input  logic                          tx_done_i,
   output logic                          busy_o,
   output logic                          eos_o
);

   localparam int Depth = NumPoints * NumCh;
   localparam int PW    = idx_width(NumPoints);
   localparam int CW    = idx_width(NumCh);
   localparam int AW    = idx_width(Depth);
   localparam int SW    = idx_width(1 << AvgLog2);
   localparam int TW    = cnt_width(SettleCycles);
   localparam int AccW  = DataWidth + AvgLog2;

   localparam logic [PW-1:0] LastPoint  = PW'(NumPoints - 1);
   localparam logic [CW-1:0] LastCh     = CW'(NumCh - 1);
   localparam logic [SW-1:0] LastSample = SW'((1 << AvgLog2) - 1);
   localparam logic [AW-1:0] LastAddr   = AW'(Depth - 1);
   localparam logic [TW-1:0] LastSettle = TW'(SettleCycles - 1);
`ifdef SWEEP_HEADER_EN
   localparam logic [7:0]    HdrCount   = 8'(Depth);
   localparam sweep_state_e  FirstTx    = ST_HDR_SYNC0;
`else
   localparam sweep_state_e  FirstTx    = ST_TX_MSB;
`endif

   sweep_state_e   state_q, state_d;
   tx_phase_e      tx_phase_q, tx_phase_d;
   logic [PW-1:0]  p_q, p_d;
   logic [CW-1:0]  c_q, c_d;
   logic [SW-1:0]  s_q, s_d;
   logic [TW-1:0]  settle_q, settle_d;
   logic [AccW-1:0] acc_q, acc_d;
   logic [AW-1:0]  wptr_q, wptr_d;
   logic [AW-1:0]  addr_q, addr_d;
   logic [7:0]     tx_data_q, tx_data_d;

   logic                 wr_en;
   logic [DataWidth-1:0] wr_data;
   logic [DataWidth-1:0] rd_data;
   logic                 is_tx;
   logic [7:0]           tx_byte;
   sweep_state_e         tx_next;
   logic                 kill;

   sweep_result_buf #(
      .Width (DataWidth),
      .Depth (Depth),
      .AddrW (AW)
   ) u_buf (
      .clk_i     (clk_i),
      .wr_en_i   (wr_en),
      .wr_addr_i (wptr_q),
      .wr_data_i (wr_data),
      .rd_addr_i (addr_d),
      .rd_data_o (rd_data)
   );

   // Next-state, counter and buffer-port logic; abort overrides everything at the end.
   always_comb begin
      state_d    = state_q;
      tx_phase_d = tx_phase_q;
      p_d        = p_q;
      c_d        = c_q;
      s_d        = s_q;
      settle_d   = settle_q;
      acc_d      = acc_q;
      wptr_d     = wptr_q;
      addr_d     = addr_q;
      tx_data_d  = tx_data_q;
      wr_en      = 1'b0;
      wr_data    = DataWidth'(acc_q >> AvgLog2);
      is_tx      = 1'b0;
      tx_byte    = 8'h00;
      tx_next    = ST_IDLE;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_DAC_WR;
               p_d     = '0;
               c_d     = '0;
               s_d     = '0;
               acc_d   = '0;
               wptr_d  = '0;
               addr_d  = '0;
            end
         end
         ST_DAC_WR: begin
            state_d = ST_DAC_WAIT;
         end
         ST_DAC_WAIT: begin
            if (dac_done_i) begin
               state_d  = ST_SETTLE;
               settle_d = '0;
            end
         end
         ST_SETTLE: begin
            if (settle_q == LastSettle) begin
               state_d = ST_ADC_CONV;
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         ST_ADC_CONV: begin
            state_d = ST_ADC_WAIT;
         end
         ST_ADC_WAIT: begin
            if (adc_done_i) begin
               acc_d = acc_q + AccW'(adc_data_i);
               if (s_q == LastSample) begin
                  state_d = ST_STORE;
               end else begin
                  s_d     = s_q + 1'b1;
                  state_d = ST_ADC_CONV;
               end
            end
         end
         ST_STORE: begin
            wr_en  = 1'b1;
            acc_d  = '0;
            s_d    = '0;
            wptr_d = wptr_q + 1'b1;
            if (c_q != LastCh) begin
               c_d     = c_q + 1'b1;
               state_d = ST_ADC_CONV;
            end else if (p_q != LastPoint) begin
               c_d     = '0;
               p_d     = p_q + 1'b1;
               state_d = ST_DAC_WR;
            end else begin
               addr_d  = '0;
               state_d = FirstTx;
            end
         end
`ifdef SWEEP_HEADER_EN
         ST_HDR_SYNC0: begin
            is_tx   = 1'b1;
            tx_byte = HDR_SYNC0;
            tx_next = ST_HDR_SYNC1;
         end
         ST_HDR_SYNC1: begin
            is_tx   = 1'b1;
            tx_byte = HDR_SYNC1;
            tx_next = ST_HDR_COUNT;
         end
         ST_HDR_COUNT: begin
            is_tx   = 1'b1;
            tx_byte = HdrCount;
            tx_next = ST_TX_MSB;
         end
`endif
         ST_TX_MSB: begin
            is_tx   = 1'b1;
            tx_byte = 8'(rd_data >> 8);
            tx_next = ST_TX_LSB;
         end
         ST_TX_LSB: begin
            is_tx   = 1'b1;
            tx_byte = rd_data[7:0];
            tx_next = (addr_q == LastAddr) ? ST_DONE : ST_TX_MSB;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (is_tx) begin
         case (tx_phase_q)
            TXP_LOAD: begin
               tx_data_d  = tx_byte;
               tx_phase_d = TXP_PULSE;
            end
            TXP_PULSE: begin
               tx_phase_d = TXP_WAIT;
            end
            default: begin
               if (tx_done_i) begin
                  tx_phase_d = TXP_LOAD;
                  state_d    = tx_next;
                  if ((state_q == ST_TX_LSB) && (tx_next == ST_TX_MSB)) begin
                     addr_d = addr_q + 1'b1;
                  end
               end
            end
         endcase
      end

      if (abort_i) begin
         state_d    = ST_IDLE;
         tx_phase_d = TXP_LOAD;
         acc_d      = '0;
         s_d        = '0;
         wr_en      = 1'b0;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         tx_phase_q <= TXP_LOAD;
         p_q        <= '0;
         c_q        <= '0;
         s_q        <= '0;
         settle_q   <= '0;
         acc_q      <= '0;
         wptr_q     <= '0;
         addr_q     <= '0;
         tx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         tx_phase_q <= tx_phase_d;
         p_q        <= p_d;
         c_q        <= c_d;
         s_q        <= s_d;
         settle_q   <= settle_d;
         acc_q      <= acc_d;
         wptr_q     <= wptr_d;
         addr_q     <= addr_d;
         tx_data_q  <= tx_data_d;
      end
   end

   // Reset or abort in the current cycle silences every pulse output.
   assign kill        = abort_i | rst_i;
   assign dac_start_o = (state_q == ST_DAC_WR) & ~kill;
   assign adc_start_o = (state_q == ST_ADC_CONV) & ~kill;
   assign tx_start_o  = is_tx & (tx_phase_q == TXP_PULSE) & ~kill;
   assign eos_o       = (state_q == ST_DONE) & ~kill;
   assign busy_o      = (state_q != ST_IDLE);
   assign dac_idx_o   = p_q;
   assign adc_ch_o    = c_q;
   assign tx_data_o   = tx_data_q;

endmodule
